// File: rtl/handshake_pkg.sv
// handshake_pkg: shared defaults and helpers for the handshake_pack width-up packer.
//   DEF_WORD_WIDTH - default input word width
//   DEF_RATIO      - default number of words per output beat
//   cnt_width()    - lane counter width for a given ratio (never below 1)
package handshake_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 8;
    localparam int unsigned DEF_RATIO      = 4;

    // Lane counter width; a single bit still covers the RATIO == 2 case.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/handshake_pack_lane.sv
// handshake_pack_lane: lane counter and collect-buffer write enables.
//   clk, rst_n  - clock, asynchronous active-low reset
//   take        - a word is accepted this cycle
//   close       - the accepted word completes the beat (cnt returns to 0)
//   cnt         - lane the next accepted word fills (registered)
//   lane_we_c   - one-hot write enable for collect lanes 0..RATIO-2 (combinational)
module handshake_pack_lane
    import handshake_pkg::*;
#(
    parameter int unsigned RATIO = DEF_RATIO
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          take,
    input  logic                          close,
    output logic [cnt_width(RATIO)-1:0]   cnt,
    output logic [RATIO-2:0]              lane_we_c
);

    localparam int unsigned CW = cnt_width(RATIO);

    logic [CW-1:0] cnt_nxt;

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Next lane and collect-buffer write enables; a closing word never lands in the buffer.
    always_comb begin
        cnt_nxt   = cnt;
        lane_we_c = '0;
        if (take) begin
            cnt_nxt = close ? '0 : cnt + CW'(1);
        end
        for (int i = 0; i < int'(RATIO) - 1; i++) begin
            lane_we_c[i] = take && !close && (cnt == CW'(i));
        end
    end

endmodule

// File: rtl/handshake_pack.sv
// handshake_pack: width-up packer, RATIO WORD_WIDTH-bit words per output beat.
//   clk, rst_n            - clock, asynchronous active-low reset
//   up_valid/up_data      - input word stream
//   up_ready              - combinational; depends on down_ready, never on up_valid
//   down_valid/down_data  - registered output beat, first word in the low lane
//   down_ready            - consumer accepts the beat
// Optional feature macro HANDSHAKE_PACK_LAST_EN adds up_last, down_last, down_keep:
//   a word with up_last closes a short beat, unfilled lanes read 0.
module handshake_pack
    import handshake_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned RATIO      = DEF_RATIO
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          up_valid,
    input  logic [WORD_WIDTH-1:0]         up_data,
`ifdef HANDSHAKE_PACK_LAST_EN
    input  logic                          up_last,
    output logic                          down_last,
    output logic [RATIO-1:0]              down_keep,
`endif
    output logic                          up_ready,
    output logic                          down_valid,
    output logic [WORD_WIDTH*RATIO-1:0]   down_data,
    input  logic                          down_ready
);

    localparam int unsigned CW = cnt_width(RATIO);

    logic [CW-1:0]                          cnt;
    logic [RATIO-2:0]                       lane_we_c;
    logic [RATIO-2:0][WORD_WIDTH-1:0]       coll;
    logic [RATIO-1:0][WORD_WIDTH-1:0]       beat_c;
    logic                                   close_c;
    logic                                   take_c;

    // The accepted word completes a beat at the top lane, or early on up_last.
`ifdef HANDSHAKE_PACK_LAST_EN
    logic [RATIO-1:0] keep_c;
    assign close_c = (cnt == CW'(RATIO - 1)) || up_last;
`else
    assign close_c = (cnt == CW'(RATIO - 1));
`endif

    // Only a closing word waits for the output register to free up.
    assign up_ready = rst_n && (!close_c || !down_valid || down_ready);
    assign take_c   = up_valid && up_ready;

    handshake_pack_lane #(
        .RATIO     (RATIO)
    ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .take      (take_c),
        .close     (close_c),
        .cnt       (cnt),
        .lane_we_c (lane_we_c)
    );

    // Collect buffer for lanes 0..RATIO-2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll <= '0;
        end else begin
            for (int i = 0; i < int'(RATIO) - 1; i++) begin
                if (lane_we_c[i]) begin
                    coll[i] <= up_data;
                end
            end
        end
    end

    // Beat image: lanes below cnt from the buffer, lane cnt from the incoming word, rest zero.
    always_comb begin
        beat_c = '0;
        for (int i = 0; i < int'(RATIO) - 1; i++) begin
            if (CW'(i) < cnt) begin
                beat_c[i] = coll[i];
            end else if (CW'(i) == cnt) begin
                beat_c[i] = up_data;
            end
        end
        if (cnt == CW'(RATIO - 1)) begin
            beat_c[RATIO-1] = up_data;
        end
    end

`ifdef HANDSHAKE_PACK_LAST_EN
    // Filled lanes are 0..cnt inclusive.
    always_comb begin
        keep_c = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            keep_c[i] = (CW'(i) <= cnt);
        end
    end
`endif

    // Output register: a new beat replaces a consumed one with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_valid <= 1'b0;
            down_data  <= '0;
`ifdef HANDSHAKE_PACK_LAST_EN
            down_last  <= 1'b0;
            down_keep  <= '0;
`endif
        end else if (take_c && close_c) begin
            down_valid <= 1'b1;
            down_data  <= beat_c;
`ifdef HANDSHAKE_PACK_LAST_EN
            down_last  <= up_last;
            down_keep  <= keep_c;
`endif
        end else if (down_ready) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_handshake_pack.sv
// tb_handshake_pack: directed bench for handshake_pack (default 8-bit words, ratio 4).
// Covers HANDSHAKE_PACK_LAST_EN when the macro is defined.
module tb_handshake_pack;

    localparam int unsigned W = 8;
    localparam int unsigned R = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             up_valid;
    logic [W-1:0]     up_data;
    logic             up_ready;
    logic             down_valid;
    logic [W*R-1:0]   down_data;
    logic             down_ready;
`ifdef HANDSHAKE_PACK_LAST_EN
    logic             up_last;
    logic             down_last;
    logic [R-1:0]     down_keep;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int beats_seen = 0;
    logic mon_en = 1'b0;
    logic [W*R-1:0] exp_q[$];

    always #5 clk = ~clk;

    handshake_pack #(
        .WORD_WIDTH (W),
        .RATIO      (R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_data    (up_data),
`ifdef HANDSHAKE_PACK_LAST_EN
        .up_last    (up_last),
        .down_last  (down_last),
        .down_keep  (down_keep),
`endif
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_ready (down_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word; wait (bounded) for up_ready, then let it transfer on the next edge.
    task automatic send(input string tag, input logic [W-1:0] w);
        int n;
        n = 0;
        up_valid = 1'b1;
        up_data  = w;
        #1;
        while (!up_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, 64'(up_ready), 64'd1);
        @(posedge clk); #1;
        up_valid = 1'b0;
    endtask

`ifdef HANDSHAKE_PACK_LAST_EN
    task automatic send_last(input string tag, input logic [W-1:0] w);
        up_last = 1'b1;
        send(tag, w);
        up_last = 1'b0;
    endtask
`endif

    // Scoreboard monitor for the random phase: every consumed beat must match in order.
    always @(negedge clk) begin
        if (mon_en && rst_n && down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                check("rand_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                check("rand_beat", 64'(down_data), 64'(exp_q.pop_front()));
                beats_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int lane;
        int cyc;
        logic [W*R-1:0] acc;

        // Reset with up_valid high.
        rst_n      = 1'b0;
        up_valid   = 1'b1;
        up_data    = 8'hFF;
        down_ready = 1'b1;
`ifdef HANDSHAKE_PACK_LAST_EN
        up_last    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(down_valid), 64'd0);
        check("rst_data",  64'(down_data),  64'd0);
        check("rst_ready", 64'(up_ready),   64'd0);
`ifdef HANDSHAKE_PACK_LAST_EN
        check("rst_keep",  64'(down_keep),  64'd0);
        check("rst_last",  64'(down_last),  64'd0);
`endif
        rst_n    = 1'b1;
        up_valid = 1'b0;
        @(posedge clk); #1;
        check("rel_ready", 64'(up_ready),   64'd1);
        check("rel_valid", 64'(down_valid), 64'd0);

        // Back-to-back stream with consumer ready.
        send("s11", 8'h11);
        send("s22", 8'h22);
        send("s33", 8'h33);
        check("s_no_early", 64'(down_valid), 64'd0);
        send("s44", 8'h44);
        check("s_valid", 64'(down_valid), 64'd1);
        check("s_data",  64'(down_data),  64'h44332211);
        @(posedge clk); #1;
        check("s_one_cycle", 64'(down_valid), 64'd0);

        // Stall: beat held, three more lanes accepted, completing word waits.
        down_ready = 1'b0;
        send("t11", 8'h11);
        send("t22", 8'h22);
        send("t33", 8'h33);
        send("t44", 8'h44);
        @(posedge clk); #1;
        check("t_held_valid", 64'(down_valid), 64'd1);
        check("t_held_data",  64'(down_data),  64'h44332211);
        send("t55", 8'h55);
        send("t66", 8'h66);
        send("t77", 8'h77);
        up_valid = 1'b1;
        up_data  = 8'h88;
        #1;
        check("t_block", 64'(up_ready), 64'd0);
        @(posedge clk); #1;
        check("t_block2",    64'(up_ready),  64'd0);
        check("t_keep_data", 64'(down_data), 64'h44332211);
        down_ready = 1'b1;
        #1;
        check("t_unblock", 64'(up_ready), 64'd1);
        @(posedge clk); #1;
        up_valid = 1'b0;
        check("t_b2b_valid", 64'(down_valid), 64'd1);
        check("t_b2b_data",  64'(down_data),  64'h88776655);
        @(posedge clk); #1;
        check("t_drain", 64'(down_valid), 64'd0);

        // Random up_valid with down_ready toggling every cycle.
        mon_en = 1'b1;
        sent = 0;
        lane = 0;
        cyc  = 0;
        acc  = '0;
        while (sent < 64 && cyc < 2000) begin
            up_valid   = 1'($urandom_range(0, 1));
            up_data    = W'(sent * 37 + 5);
            down_ready = ~down_ready;
            @(negedge clk);
            if (up_valid && up_ready) begin
                acc[lane*W +: W] = up_data;
                lane++;
                sent++;
                if (lane == int'(R)) begin
                    exp_q.push_back(acc);
                    lane = 0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("rand_sent",  64'(sent),          64'd64);
        check("rand_beats", 64'(beats_seen),    64'd16);
        check("rand_empty", 64'(exp_q.size()),  64'd0);

        // Asynchronous reset mid-beat while a beat is held.
        down_ready = 1'b0;
        send("a01", 8'h01);
        send("a02", 8'h02);
        send("a03", 8'h03);
        send("a04", 8'h04);
        send("aA1", 8'hA1);
        send("aA2", 8'hA2);
        check("a_held", 64'(down_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("a_rst_valid", 64'(down_valid), 64'd0);
        check("a_rst_data",  64'(down_data),  64'd0);
        check("a_rst_ready", 64'(up_ready),   64'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        down_ready = 1'b1;
        send("bB1", 8'hB1);
        send("bB2", 8'hB2);
        send("bB3", 8'hB3);
        send("bB4", 8'hB4);
        check("b_valid", 64'(down_valid), 64'd1);
        check("b_data",  64'(down_data),  64'hB4B3B2B1);

`ifdef HANDSHAKE_PACK_LAST_EN
        // Short beat closed by up_last, then a full beat from lane 0.
        @(posedge clk); #1;
        send("cC1", 8'hC1);
        send_last("cC2", 8'hC2);
        check("c_valid", 64'(down_valid), 64'd1);
        check("c_data",  64'(down_data),  64'h0000C2C1);
        check("c_keep",  64'(down_keep),  64'b0011);
        check("c_last",  64'(down_last),  64'd1);
        send("dD1", 8'hD1);
        send("dD2", 8'hD2);
        send("dD3", 8'hD3);
        send("dD4", 8'hD4);
        check("d_data", 64'(down_data), 64'hD4D3D2D1);
        check("d_keep", 64'(down_keep), 64'b1111);
        check("d_last", 64'(down_last), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/handshake_pack.md
# handshake_pack

Width-up packer that accepts a stream of WORD_WIDTH-bit words on a valid/ready interface and emits RATIO-word beats on a wider valid/ready interface. It sits directly downstream of the byte-wide valid/ready pipeline register, consuming its down_* side. It feeds wide datapaths such as bus writers and FIFOs. Full throughput: one word accepted per cycle, with no bubbles at beat boundaries when the consumer is ready.

## Interface
- WORD_WIDTH, 8, width of one input word
- RATIO, 4, words per output beat; legal range 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- up_valid  input  1  input word valid
- up_data  input  WORD_WIDTH  input word
- up_ready  output  1  packer can accept a word this cycle
- down_valid  output  1  output beat valid
- down_data  output  WORD_WIDTH*RATIO  packed beat; first-accepted word in bits [WORD_WIDTH-1:0]
- down_ready  input  1  consumer accepts the beat this cycle
- up_last, down_last, down_keep[RATIO-1:0]: present only with the macro (see Configuration)

## Operation
- Transfer on either side occurs only at a rising edge with valid && ready both high.
- lane counter cnt, width $clog2(RATIO), reset 0. It points at the lane that the next accepted word fills.
- Collect buffer holds lanes 0..RATIO-2. Accepted word with cnt < RATIO-1 is written to lane cnt; cnt increments.
- Word accepted at cnt == RATIO-1 completes the beat:
  - collect buffer lanes plus this word load the output register;
  - down_valid set;
  - cnt wraps to 0.
- up_ready = rst_n && ((cnt != RATIO-1) || !down_valid || down_ready). Lanes 0..RATIO-2 are accepted even while a beat is stalled; only the completing word waits.
- Output register: down_valid clears on down_ready when no new beat completes that cycle. When both happen in the same cycle, the new beat replaces the old one and down_valid stays 1.
- While down_valid && !down_ready, down_data is held stable.
- Input is not required to hold valid; gaps are allowed between words of a beat.

## Timing
- Reset (async assert, sync-to-clk deassert by system) forces:
  - down_valid=0, down_data=0, cnt=0, collect buffer=0;
  - up_ready=0 while rst_n low.
- Reset mid-beat discards partial lanes. The first word after release goes to lane 0.
- Latency: the completing word accepted at edge k drives down_valid=1 and the full down_data after edge k.
- Combinational path exists from down_ready to up_ready only. No path from up_valid to any output.
- Boundary conditions:
  - cnt wrap RATIO-1 → 0;
  - completing word plus down_ready in the same cycle gives back-to-back beats;
  - completing word while stalled waits with up_ready=0, with no data loss or duplication.

## Configuration
- Macro HANDSHAKE_PACK_LAST_EN.
- Defined: adds the up_last input, plus down_last and down_keep outputs. Both outputs reset to 0.
  - An accepted word with up_last=1 closes the beat at any cnt; cnt returns to 0.
  - Unfilled lanes of down_data read 0.
  - down_keep bit i=1 for each filled lane.
  - down_last=1 for that beat.
  - For an up_last beat, up_ready follows the completing-word rule at any cnt.
- Undefined: the ports do not exist and beats are always full RATIO words.

## Structure
- Shared package handshake_pkg contains:
  - default WORD_WIDTH and RATIO constants;
  - function for the counter width.
- One natural sub-module, handshake_pack_lane, which holds the lane counter and the collect buffer write enables. Output register logic lives in the top.

## Test plan
- Reset: rst_n=0 with up_valid=1 → down_valid=0, down_data=0, up_ready=0. After release, up_ready=1 and nothing is emitted.
- Stream 0x11,0x22,0x33,0x44 back-to-back with down_ready=1 → down_data=0x44332211, down_valid high for exactly one cycle, starting the cycle after the 0x44 accept.
- Stall: hold the beat with down_ready=0, then send 0x55,0x66,0x77,0x88.
  - First three are accepted; up_ready=0 at cnt=3.
  - Raise down_ready → 0x44332211 is consumed and 0x88776655 appears next cycle with no bubble.
- Random up_valid plus down_ready toggling every cycle, 64 words → scoreboard shows in-order beats with no loss or duplication.
- Accept 0xA1,0xA2, then assert rst_n low asynchronously → down_valid=0 immediately. After release, 0xB1..0xB4 give 0xB4B3B2B1.
- With HANDSHAKE_PACK_LAST_EN: 0xC1,0xC2 with up_last on 0xC2 → down_data=0x0000C2C1, down_keep=4'b0011, down_last=1. The next beat starts at lane 0.
